// File: rtl/bpsk_bit_framer.sv
// bpsk_bit_framer: frame builder and bit serializer in front of bpsk_modulator.
// Emits an alternating preamble, then a sync word, then payload bytes taken
// from a valid/ready stream, MSB-first, with each bit held SAMPLES_PER_BIT clocks.
// Optional build macro: BPSK_FRAMER_DIFF_ENC_EN enables differential (DBPSK)
// encoding of the emitted bit stream; left undefined, raw bits go out directly.
module bpsk_bit_framer #(
  parameter int                    SAMPLES_PER_BIT = 256,
  parameter int                    PREAMBLE_BITS   = 16,
  parameter int                    SYNC_WIDTH      = 16,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD       = 16'hD391
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       mod_s,
  output logic       mod_en,
  output logic       busy,
  output logic       underrun
);

  // Counter widths: the bit index must cover the longest field, which is at
  // least one payload byte (8 bits), so it is never narrower than 3 bits.
  localparam int TICK_W    = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int MAX_A     = (PREAMBLE_BITS > SYNC_WIDTH) ? PREAMBLE_BITS : SYNC_WIDTH;
  localparam int MAX_FIELD = (MAX_A > 8) ? MAX_A : 8;
  localparam int BIT_W     = $clog2(MAX_FIELD);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  PRE_LAST  = BIT_W'(PREAMBLE_BITS - 1);
  localparam logic [BIT_W-1:0]  SYNC_LAST = BIT_W'(SYNC_WIDTH - 1);
  localparam logic [BIT_W-1:0]  BYTE_LAST = BIT_W'(7);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    SYNC,
    PAYLOAD
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
  logic [7:0]          shreg_q, shreg_d;
  logic                last_flag_q, last_flag_d;
  logic                underrun_q, underrun_d;

  logic                bit_end;
  logic                fetch;
  logic                raw_bit;
  logic [SYNC_WIDTH-1:0] sync_shift;

  assign bit_end    = (tick_cnt_q == TICK_LAST);
  assign sync_shift = SYNC_WORD << bit_idx_q;

  // State and datapath registers; reset drops any frame in progress silently.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      last_flag_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      last_flag_q <= last_flag_d;
      underrun_q  <= underrun_d;
    end
  end

  // Next-state logic: walks the fields bit by bit and decides at each fetch
  // point whether a new byte is loaded or the frame is aborted as an underrun.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = bit_end ? '0 : tick_cnt_q + TICK_W'(1);
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    last_flag_d = last_flag_q;
    underrun_d  = 1'b0;
    fetch       = 1'b0;
    raw_bit     = 1'b0;

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        bit_idx_d  = '0;
        if (in_valid) begin
          state_d = PREAMBLE;
        end
      end

      PREAMBLE: begin
        raw_bit = ~bit_idx_q[0];
        if (bit_end) begin
          if (bit_idx_q == PRE_LAST) begin
            state_d   = SYNC;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end
      end

      SYNC: begin
        raw_bit = sync_shift[SYNC_WIDTH-1];
        if (bit_end) begin
          if (bit_idx_q == SYNC_LAST) begin
            fetch = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end
      end

      PAYLOAD: begin
        raw_bit = shreg_q[7];
        if (bit_end) begin
          shreg_d = {shreg_q[6:0], 1'b0};
          if (bit_idx_q == BYTE_LAST) begin
            if (last_flag_q) begin
              state_d   = IDLE;
              bit_idx_d = '0;
            end else begin
              fetch = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (fetch) begin
      bit_idx_d = '0;
      if (in_valid) begin
        shreg_d     = in_data;
        last_flag_d = in_last;
        state_d     = PAYLOAD;
      end else begin
        state_d    = IDLE;
        underrun_d = 1'b1;
      end
    end
  end

  assign in_ready = fetch & ~arst;
  assign mod_en   = (state_q != IDLE);
  assign busy     = (state_q != IDLE);
  assign underrun = underrun_q;

`ifdef BPSK_FRAMER_DIFF_ENC_EN
  logic prev_q, prev_d;

  // Last emitted symbol, captured on bit boundaries and cleared while idle so
  // each frame's differential chain starts from zero.
  always_ff @(posedge clk) begin
    if (arst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  // Differential encoder: the emitted symbol toggles whenever the raw bit is 1.
  always_comb begin
    prev_d = prev_q;
    mod_s  = 1'b0;
    if (state_q != IDLE) begin
      mod_s = raw_bit ^ prev_q;
      if (bit_end) begin
        prev_d = mod_s;
      end
    end else begin
      prev_d = 1'b0;
    end
  end
`else
  assign mod_s = raw_bit;
`endif

endmodule

// File: tb/tb_bpsk_bit_framer.sv
// tb_bpsk_bit_framer: directed, table-driven bench for bpsk_bit_framer with
// short fields (4 samples/bit, 4 preamble bits, 8-bit sync word 8'hD3).
// Honours BPSK_FRAMER_DIFF_ENC_EN by encoding its own expected symbols.
module tb_bpsk_bit_framer;

  logic       clk;
  logic       arst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       mod_s;
  logic       mod_en;
  logic       busy;
  logic       underrun;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic       arst;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       expEn;
    logic       rawS;
    logic       expReady;
    logic       expUnderrun;
    logic       bitEnd;
    int         hold;
    string      name;
  } vec_t;

  vec_t vecs[$];

  bpsk_bit_framer #(
    .SAMPLES_PER_BIT(4),
    .PREAMBLE_BITS  (4),
    .SYNC_WIDTH     (8),
    .SYNC_WORD      (8'hD3)
  ) dut (
    .clk     (clk),
    .arst    (arst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_last (in_last),
    .in_ready(in_ready),
    .mod_s   (mod_s),
    .mod_en  (mod_en),
    .busy    (busy),
    .underrun(underrun)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends even if the sequencing goes astray.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic a, input logic v, input logic [7:0] d, input logic l);
    arst     = a;
    in_valid = v;
    in_data  = d;
    in_last  = l;
  endtask

  task automatic checkOutput(input string nm, input logic act, input logic exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at time %0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic doCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic addVec(input logic a, input logic v, input logic [7:0] d, input logic l,
                        input logic en, input logic s, input logic rdy, input logic und,
                        input logic be, input int h, input string nm);
    vec_t t;
    t.arst = a; t.valid = v; t.data = d; t.last = l;
    t.expEn = en; t.rawS = s; t.expReady = rdy; t.expUnderrun = und;
    t.bitEnd = be; t.hold = h; t.name = nm;
    vecs.push_back(t);
  endtask

  initial begin
    logic [3:0] preBits;
    logic [7:0] syncBits;
    logic [7:0] payA5;
    logic       prevModel;
    logic       expS;
    logic       expRdy;

    testsRun    = 0;
    testsFailed = 0;
    prevModel   = 1'b0;

    preBits  = 4'b1010;
    syncBits = 8'b11010011;
    payA5    = 8'b10100101;

    // Reset for two clocks with a byte already waiting, then single byte A5.
    addVec(1, 1, 8'hA5, 1, 0, 0, 0, 0, 0, 1, "resetHold");
    addVec(0, 1, 8'hA5, 1, 0, 0, 0, 0, 0, 1, "idleStart1");
    for (int i = 0; i < 4; i++)
      addVec(0, 1, 8'hA5, 1, 1, preBits[3-i], 0, 0, 1, 4, "f1Preamble");
    for (int i = 0; i < 8; i++)
      addVec(0, 1, 8'hA5, 1, 1, syncBits[7-i], (i == 7), 0, 1, 4, "f1Sync");
    for (int i = 0; i < 8; i++)
      addVec(0, 1, 8'hA5, 1, 1, payA5[7-i], 0, 0, 1, 4, "f1Payload");
    addVec(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 2, "f1Idle");

    // Two bytes 00 then FF, the second shown only at its fetch cycle.
    addVec(0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 1, "idleStart2");
    for (int i = 0; i < 4; i++)
      addVec(0, 1, 8'h00, 0, 1, preBits[3-i], 0, 0, 1, 4, "f2Preamble");
    for (int i = 0; i < 8; i++)
      addVec(0, 1, 8'h00, 0, 1, syncBits[7-i], (i == 7), 0, 1, 4, "f2Sync");
    for (int i = 0; i < 7; i++)
      addVec(0, 0, 8'h00, 0, 1, 0, 0, 0, 1, 4, "f2Byte0");
    addVec(0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 3, "f2Byte0Bit7");
    addVec(0, 1, 8'hFF, 1, 1, 0, 1, 0, 1, 1, "f2Fetch1");
    for (int i = 0; i < 8; i++)
      addVec(0, 0, 8'h00, 0, 1, 1, 0, 0, 1, 4, "f2Byte1");
    addVec(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 2, "f2Idle");

    applyStimulus(1, 1, 8'hA5, 1);
    @(posedge clk);
    #1;

    for (int k = 0; k < vecs.size(); k++) begin
      for (int h = 0; h < vecs[k].hold; h++) begin
        applyStimulus(vecs[k].arst, vecs[k].valid, vecs[k].data, vecs[k].last);
        @(negedge clk);
        expS   = vecs[k].expEn ? (vecs[k].rawS ^ prevModel) : 1'b0;
        expRdy = (h == vecs[k].hold - 1) ? vecs[k].expReady : 1'b0;
        checkOutput({vecs[k].name, ".mod_en"},   mod_en,   vecs[k].expEn);
        checkOutput({vecs[k].name, ".mod_s"},    mod_s,    expS);
        checkOutput({vecs[k].name, ".busy"},     busy,     vecs[k].expEn);
        checkOutput({vecs[k].name, ".in_ready"}, in_ready, expRdy);
        checkOutput({vecs[k].name, ".underrun"}, underrun, vecs[k].expUnderrun);
        @(posedge clk);
        #1;
      end
`ifdef BPSK_FRAMER_DIFF_ENC_EN
      if (!vecs[k].expEn)
        prevModel = 1'b0;
      else if (vecs[k].bitEnd)
        prevModel = vecs[k].rawS ^ prevModel;
`endif
    end

    // Underrun: one byte with last=0, then no data at the next fetch point.
    applyStimulus(0, 1, 8'h3C, 0);
    @(negedge clk);
    checkOutput("urIdle.mod_en", mod_en, 1'b0);
    @(posedge clk);
    #1;
    doCycles(47);
    @(negedge clk);
    checkOutput("urFetch0.in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 8'h00, 0);
    doCycles(31);
    @(negedge clk);
    checkOutput("urFetch1.in_ready", in_ready, 1'b1);
    checkOutput("urFetch1.mod_en", mod_en, 1'b1);
    checkOutput("urFetch1.underrun", underrun, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("urPulse.underrun", underrun, 1'b1);
    checkOutput("urPulse.mod_en", mod_en, 1'b0);
    checkOutput("urPulse.busy", busy, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("urAfter.underrun", underrun, 1'b0);

    // New frame after the underrun, then reset at frame clock 60.
    @(posedge clk);
    #1;
    applyStimulus(0, 1, 8'hA5, 1);
    @(negedge clk);
    checkOutput("restartIdle.mod_en", mod_en, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("restart.mod_en", mod_en, 1'b1);
    checkOutput("restart.mod_s", mod_s, 1'b1);
    @(posedge clk);
    #1;
    doCycles(59);
    applyStimulus(1, 1, 8'hA5, 1);
    @(negedge clk);
    checkOutput("midReset.mod_en", mod_en, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("postReset.mod_en", mod_en, 1'b0);
    checkOutput("postReset.mod_s", mod_s, 1'b0);
    checkOutput("postReset.busy", busy, 1'b0);
    checkOutput("postReset.in_ready", in_ready, 1'b0);
    checkOutput("postReset.underrun", underrun, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 8'h00, 0);
    @(negedge clk);
    checkOutput("resetRelease.underrun", underrun, 1'b0);
    checkOutput("resetRelease.mod_en", mod_en, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("resetIdle.mod_en", mod_en, 1'b0);
    checkOutput("resetIdle.underrun", underrun, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
